// File: rtl/spmm_seq_ctrl.sv
// SpMM tile sequencer: owns the rhs/lhs/out handshakes, issues NCOL rhs columns into the
// fixed-latency PE, tracks in-flight results and drives the output accumulator controls.
module spmm_seq_ctrl #(
  parameter int N    = 16,
  parameter int LAT  = $clog2(N) + 1,
  parameter int NCOL = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rhs_start,
  output logic                    rhs_ready,
  output logic                    rhs_load,
  input  logic                    lhs_start,
  input  logic                    lhs_ws,
  input  logic                    lhs_os,
  output logic                    lhs_ready,
  output logic                    lhs_load,
  output logic                    issue_valid,
  output logic [$clog2(NCOL)-1:0] issue_sel,
  output logic                    res_valid,
  output logic [$clog2(NCOL)-1:0] res_sel,
  output logic                    res_add,
  output logic                    out_ready,
  input  logic                    out_start,
  output logic                    busy,
  output logic [15:0]             op_cnt
);

  localparam int SELW = $clog2(NCOL);
  localparam logic [SELW-1:0] LAST_COL = SELW'(NCOL - 1);

  localparam logic [2:0] S_EMPTY  = 3'd0;
  localparam logic [2:0] S_LOADED = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [SELW-1:0] col_cnt;
  logic            ws_q;
  logic            os_q;
  logic [LAT-1:0]  vld_p;
  logic [SELW-1:0] sel_p [LAT];
  logic            pipe_busy;
  logic            op_done;

  // Handshake decode: readies come straight from registered state, loads are start AND ready.
  assign rhs_ready   = (state == S_EMPTY);
  assign lhs_ready   = (state == S_LOADED);
  assign out_ready   = (state == S_HOLD);
  assign issue_valid = (state == S_ISSUE);
  assign busy        = (state == S_ISSUE) || (state == S_DRAIN);
  assign rhs_load    = rhs_start && rhs_ready;
  assign lhs_load    = lhs_start && lhs_ready;
  assign issue_sel   = issue_valid ? col_cnt : '0;

  assign pipe_busy = |vld_p;
  assign op_done   = (state == S_DRAIN) && !pipe_busy;

  assign res_valid = vld_p[LAT-1];
  assign res_sel   = sel_p[LAT-1];
  assign res_add   = res_valid && os_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY:  if (rhs_load) state_nxt = S_LOADED;
      S_LOADED: if (lhs_load) state_nxt = S_ISSUE;
      S_ISSUE:  if (col_cnt == LAST_COL) state_nxt = S_DRAIN;
      S_DRAIN:  if (!pipe_busy) state_nxt = S_HOLD;
      S_HOLD:   if (out_start) state_nxt = ws_q ? S_LOADED : S_EMPTY;
      default:  state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_EMPTY;
      col_cnt <= '0;
      ws_q    <= 1'b0;
      os_q    <= 1'b0;
      op_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (lhs_load) begin
        col_cnt <= '0;
        ws_q    <= lhs_ws;
        os_q    <= lhs_os;
      end else if (issue_valid) begin
        col_cnt <= col_cnt + 1'b1;
      end
      if (op_done) op_cnt <= op_cnt + 16'd1;
    end
  end

  // Result-tracking pipe: stage LAT-1 lines up with the PE output of the matching issue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
      for (int i = 0; i < LAT; i++) sel_p[i] <= '0;
    end else begin
      vld_p    <= {vld_p[LAT-2:0], issue_valid};
      sel_p[0] <= issue_sel;
      for (int i = 1; i < LAT; i++) sel_p[i] <= sel_p[i-1];
    end
  end

endmodule

// File: tb/tb_spmm_seq_ctrl.sv
// Bench for spmm_seq_ctrl: table of operations plus hand-written reset/abort/wrap sequences,
// with a result scoreboard checked against res_valid/res_sel/res_add every cycle.
module tb_spmm_seq_ctrl;

  localparam int LAT = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rhs_start = 1'b0;
  logic        lhs_start = 1'b0;
  logic        lhs_ws = 1'b0;
  logic        lhs_os = 1'b0;
  logic        out_start = 1'b0;
  logic        rhs_ready, rhs_load, lhs_ready, lhs_load;
  logic        issue_valid, res_valid, res_add, out_ready, busy;
  logic [1:0]  issue_sel, res_sel;
  logic [15:0] op_cnt;

  spmm_seq_ctrl #(.N(16), .LAT(LAT), .NCOL(4)) dut (
    .clock(clock), .reset(reset),
    .rhs_start(rhs_start), .rhs_ready(rhs_ready), .rhs_load(rhs_load),
    .lhs_start(lhs_start), .lhs_ws(lhs_ws), .lhs_os(lhs_os),
    .lhs_ready(lhs_ready), .lhs_load(lhs_load),
    .issue_valid(issue_valid), .issue_sel(issue_sel),
    .res_valid(res_valid), .res_sel(res_sel), .res_add(res_add),
    .out_ready(out_ready), .out_start(out_start),
    .busy(busy), .op_cnt(op_cnt)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_fail = 0;
  logic [15:0] exp_ops = 16'd0;

  typedef struct {
    int         due;
    logic [1:0] sel;
    logic       add;
  } res_t;
  res_t sb[$];

  typedef struct {
    bit ws;
    bit os;
    bit inject;
    bit exp_rhs;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  // Result monitor: each scoreboard entry must appear exactly in its due cycle.
  always @(negedge clock) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      res_t e;
      e = sb.pop_front();
      chk("res_valid", 32'(res_valid), 32'(1'b1));
      chk("res_sel", 32'(res_sel), 32'(e.sel));
      chk("res_add", 32'(res_add), 32'(e.add));
    end else if (res_valid) begin
      chk("res_unexpected", 32'(res_valid), 32'(1'b0));
    end
  end

  task automatic push_results(input int t, input bit os);
    for (int k = 0; k < 4; k++) begin
      res_t e;
      e.due = t + 1 + LAT + k;
      e.sel = 2'(k);
      e.add = os;
      sb.push_back(e);
    end
  endtask

  task automatic run_op(input bit ws, input bit os, input bit inject, input bit exp_rhs);
    int t;
    int w;
    tick;
    chk("rhs_ready_pre", 32'(rhs_ready), 32'(exp_rhs));
    chk("lhs_ready_pre", 32'(lhs_ready), 32'(!exp_rhs));
    rhs_start = 1'b1;
    #1;
    chk("rhs_load", 32'(rhs_load), 32'(exp_rhs));
    tick;
    rhs_start = 1'b0;
    chk("lhs_ready_loaded", 32'(lhs_ready), 32'(1'b1));
    chk("rhs_ready_loaded", 32'(rhs_ready), 32'(1'b0));
    if (exp_rhs) tick;
    lhs_start = 1'b1;
    lhs_ws = ws;
    lhs_os = os;
    #1;
    chk("lhs_load", 32'(lhs_load), 32'(1'b1));
    t = cyc;
    push_results(t, os);
    for (int k = 0; k < 4; k++) begin
      tick;
      if (k == 0) lhs_start = 1'b0;
      chk("issue_valid", 32'(issue_valid), 32'(1'b1));
      chk("issue_sel", 32'(issue_sel), 32'(k));
      chk("busy_issue", 32'(busy), 32'(1'b1));
      if (inject && k == 1) begin
        lhs_start = 1'b1;
        rhs_start = 1'b1;
        #1;
        chk("lhs_load_ignored", 32'(lhs_load), 32'(1'b0));
        chk("rhs_load_ignored", 32'(rhs_load), 32'(1'b0));
      end
      if (k == 2) begin
        lhs_start = 1'b0;
        rhs_start = 1'b0;
      end
    end
    tick;
    chk("issue_done", 32'(issue_valid), 32'(1'b0));
    chk("busy_drain", 32'(busy), 32'(1'b1));
    if (inject) begin
      out_start = 1'b1;
      tick;
      out_start = 1'b0;
      chk("out_ready_drain", 32'(out_ready), 32'(1'b0));
      chk("busy_after_out_start", 32'(busy), 32'(1'b1));
      chk("op_cnt_drain", 32'(op_cnt), 32'(exp_ops));
    end
    w = 0;
    while (!out_ready && w < 40) begin
      tick;
      w++;
    end
    chk("out_ready", 32'(out_ready), 32'(1'b1));
    chk("out_ready_cycle", 32'(cyc), 32'(t + 6 + LAT));
    exp_ops = exp_ops + 16'd1;
    chk("op_cnt", 32'(op_cnt), 32'(exp_ops));
    chk("busy_hold", 32'(busy), 32'(1'b0));
    chk("results_drained", 32'(sb.size()), 32'(0));
    tick;
    chk("out_ready_held", 32'(out_ready), 32'(1'b1));
    out_start = 1'b1;
    tick;
    out_start = 1'b0;
    chk("rhs_ready_post", 32'(rhs_ready), 32'(!ws));
    chk("lhs_ready_post", 32'(lhs_ready), 32'(ws));
    chk("out_ready_post", 32'(out_ready), 32'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{ws: 1'b0, os: 1'b0, inject: 1'b0, exp_rhs: 1'b1};
    tbl[1] = '{ws: 1'b1, os: 1'b0, inject: 1'b1, exp_rhs: 1'b1};
    tbl[2] = '{ws: 1'b0, os: 1'b1, inject: 1'b0, exp_rhs: 1'b0};
    tbl[3] = '{ws: 1'b1, os: 1'b1, inject: 1'b1, exp_rhs: 1'b1};
    tbl[4] = '{ws: 1'b1, os: 1'b0, inject: 1'b0, exp_rhs: 1'b0};
    tbl[5] = '{ws: 1'b0, os: 1'b1, inject: 1'b0, exp_rhs: 1'b0};

    repeat (2) tick;
    chk("rst_rhs_ready", 32'(rhs_ready), 32'(1'b1));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_op_cnt", 32'(op_cnt), 32'(0));
    reset = 1'b0;
    tick;
    chk("idle_rhs_ready", 32'(rhs_ready), 32'(1'b1));
    chk("idle_lhs_ready", 32'(lhs_ready), 32'(1'b0));
    chk("idle_out_ready", 32'(out_ready), 32'(1'b0));
    chk("idle_issue", 32'(issue_valid), 32'(1'b0));

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].ws, tbl[i].os, tbl[i].inject, tbl[i].exp_rhs);

    // Asynchronous reset in the middle of ISSUE, checked before any further clock edge.
    tick;
    rhs_start = 1'b1;
    tick;
    rhs_start = 1'b0;
    lhs_start = 1'b1;
    lhs_ws = 1'b1;
    lhs_os = 1'b1;
    tick;
    lhs_start = 1'b0;
    chk("pre_reset_issue", 32'(issue_valid), 32'(1'b1));
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rhs_ready", 32'(rhs_ready), 32'(1'b1));
    chk("async_lhs_ready", 32'(lhs_ready), 32'(1'b0));
    chk("async_issue_valid", 32'(issue_valid), 32'(1'b0));
    chk("async_issue_sel", 32'(issue_sel), 32'(0));
    chk("async_busy", 32'(busy), 32'(1'b0));
    chk("async_out_ready", 32'(out_ready), 32'(1'b0));
    chk("async_res_valid", 32'(res_valid), 32'(1'b0));
    chk("async_res_add", 32'(res_add), 32'(1'b0));
    chk("async_op_cnt", 32'(op_cnt), 32'(0));
    repeat (2) tick;
    reset = 1'b0;
    exp_ops = 16'd0;
    tick;
    chk("post_reset_rhs_ready", 32'(rhs_ready), 32'(1'b1));
    chk("post_reset_lhs_ready", 32'(lhs_ready), 32'(1'b0));

    // Abort in DRAIN after two results came out: the remaining two must never appear.
    begin
      int t;
      rhs_start = 1'b1;
      tick;
      rhs_start = 1'b0;
      lhs_start = 1'b1;
      lhs_ws = 1'b0;
      lhs_os = 1'b1;
      t = cyc;
      push_results(t, 1'b1);
      tick;
      lhs_start = 1'b0;
      repeat (LAT + 1) tick;
      chk("abort_in_drain", 32'(busy && !issue_valid), 32'(1'b1));
      @(posedge clock);
      #2;
      reset = 1'b1;
      sb.delete();
      #1;
      chk("abort_busy", 32'(busy), 32'(1'b0));
      chk("abort_res_valid", 32'(res_valid), 32'(1'b0));
      repeat (2) tick;
      reset = 1'b0;
      repeat (10) tick;
      chk("abort_op_cnt", 32'(op_cnt), 32'(0));
      chk("abort_rhs_ready", 32'(rhs_ready), 32'(1'b1));
    end

    // Counter wrap from all-ones.
    force dut.op_cnt = 16'hFFFF;
    tick;
    release dut.op_cnt;
    exp_ops = 16'hFFFF;
    chk("wrap_preload", 32'(op_cnt), 32'(16'hFFFF));
    run_op(1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrap_zero", 32'(op_cnt), 32'(0));

    repeat (LAT + 2) tick;
    chk("sb_empty_end", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
